// File: rtl/alu_md_pkg.sv
// Shared constants for the MIPS EX-stage ALU control and multiply/divide unit:
// opcode classes, funct codes, ALU operation codes, result-mux selects, sequencer states.
package alu_md_pkg;

    localparam int ALUOP_ADDI  = 1;
    localparam int ALUOP_ANDI  = 2;
    localparam int ALUOP_ORI   = 3;
    localparam int ALUOP_LUI   = 4;
    localparam int ALUOP_LW    = 5;
    localparam int ALUOP_SW    = 6;
    localparam int ALUOP_RTYPE = 7;
    localparam int ALUOP_BNE   = 8;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_LUI  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_BNE  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_NONE = 4'b1001;

    localparam logic [1:0] HILO_ALU = 2'b00;
    localparam logic [1:0] HILO_HI  = 2'b01;
    localparam logic [1:0] HILO_LO  = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_control_core.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide,
// sign correction and the architectural HI/LO registers.
module md_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         run_i,
    input  logic         fix_i,
    input  logic         op_div_i,
    input  logic         op_signed_i,
    input  logic [W-1:0] rs_i,
    input  logic [W-1:0] rt_i,
    output logic         last_o,
    output logic         done_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;
    logic [W-1:0]   rs_q;
    logic           div_q;
    logic           neg_a_q;
    logic           neg_r_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           rs_neg;
    logic           rt_neg;
    logic [W-1:0]   rs_mag;
    logic [W-1:0]   rt_mag;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   hi_d;
    logic [W-1:0]   lo_d;

    always_comb begin
        rs_neg = op_signed_i & rs_i[W-1];
        rt_neg = op_signed_i & rt_i[W-1];
        rs_mag = rs_neg ? (-rs_i) : rs_i;
        rt_mag = rt_neg ? (-rt_i) : rt_i;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[W]) begin
            div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end

        prod_fix = neg_a_q ? (-acc_q) : acc_q;
        quo_fix  = neg_a_q ? (-acc_q[W-1:0]) : acc_q[W-1:0];
        rem_fix  = neg_r_q ? (-acc_q[2*W-1:W]) : acc_q[2*W-1:W];

        if (!div_q) begin
            hi_d = prod_fix[2*W-1:W];
            lo_d = prod_fix[W-1:0];
        end else if (opnd_q == '0) begin
            hi_d = rs_q;
            lo_d = '1;
        end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            opnd_q  <= '0;
            rs_q    <= '0;
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (start_i) begin
                acc_q   <= op_div_i ? {{W{1'b0}}, rs_mag} : {{W{1'b0}}, rt_mag};
                opnd_q  <= op_div_i ? rt_mag : rs_mag;
                rs_q    <= rs_i;
                div_q   <= op_div_i;
                neg_a_q <= rs_neg ^ rt_neg;
                neg_r_q <= rs_neg;
                cnt_q   <= '0;
            end else if (run_i) begin
                acc_q <= div_q ? div_next : mul_next;
                cnt_q <= cnt_q + CW'(1);
            end
            if (fix_i) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end
    end

    assign last_o = (cnt_q == CW'(W - 1));
    assign done_o = fix_i;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control: funct/ALUOp decode, HI/LO read-out mux, stall generation
// and the IDLE/RUN/FIX sequencer driving the iterative multiply/divide core.
module alu_md_control
    import alu_md_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue,
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [5:0]             ALUFunction,
    input  logic [DATA_WIDTH-1:0]  rs_data,
    input  logic [DATA_WIDTH-1:0]  rt_data,
    output logic [3:0]             ALUOperation,
    output logic [1:0]             hilo_sel,
    output logic [DATA_WIDTH-1:0]  hilo_data,
    output logic                   stall,
    output logic                   busy,
    output logic                   md_done,
    output logic [1:0]             dbg_state
);

    md_state_e state_q, state_d;

    logic                  is_rtype;
    logic                  is_md;
    logic                  is_mf;
    logic                  start;
    logic                  run;
    logic                  fix;
    logic                  core_last;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    assign is_rtype = (ALUOp == ALUOP_WIDTH'(ALUOP_RTYPE));
    assign is_md    = is_rtype && is_md_funct(ALUFunction);
    assign is_mf    = is_rtype && ((ALUFunction == F_MFHI) || (ALUFunction == F_MFLO));

    always_comb begin
        ALUOperation = ALU_NONE;
        if (is_rtype) begin
            case (ALUFunction)
                F_ADD:   ALUOperation = ALU_ADD;
                F_AND:   ALUOperation = ALU_AND;
                F_NOR:   ALUOperation = ALU_NOR;
                F_OR:    ALUOperation = ALU_OR;
                F_SLL:   ALUOperation = ALU_SLL;
                F_SRL:   ALUOperation = ALU_SRL;
                default: ALUOperation = ALU_NONE;
            endcase
        end else begin
            case (ALUOp)
                ALUOP_WIDTH'(ALUOP_ADDI): ALUOperation = ALU_ADD;
                ALUOP_WIDTH'(ALUOP_ANDI): ALUOperation = ALU_AND;
                ALUOP_WIDTH'(ALUOP_ORI):  ALUOperation = ALU_OR;
                ALUOP_WIDTH'(ALUOP_LUI):  ALUOperation = ALU_LUI;
                ALUOP_WIDTH'(ALUOP_LW):   ALUOperation = ALU_ADD;
                ALUOP_WIDTH'(ALUOP_SW):   ALUOperation = ALU_ADD;
                ALUOP_WIDTH'(ALUOP_BNE):  ALUOperation = ALU_BNE;
                default:                  ALUOperation = ALU_NONE;
            endcase
        end
    end

    always_comb begin
        hilo_sel  = HILO_ALU;
        hilo_data = '0;
        if (is_rtype && (ALUFunction == F_MFHI)) begin
            hilo_sel  = HILO_HI;
            hilo_data = hi;
        end else if (is_rtype && (ALUFunction == F_MFLO)) begin
            hilo_sel  = HILO_LO;
            hilo_data = lo;
        end
    end

    assign busy      = (state_q != MD_IDLE);
    assign stall     = busy & issue & (is_md | is_mf);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        run     = 1'b0;
        fix     = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (issue && is_md) begin
                    start   = 1'b1;
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                run = 1'b1;
                if (core_last) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                fix     = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // funct bit 1 selects divide, bit 0 selects the unsigned variant.
    md_iter_core #(
        .W (DATA_WIDTH)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .run_i       (run),
        .fix_i       (fix),
        .op_div_i    (ALUFunction[1]),
        .op_signed_i (~ALUFunction[0]),
        .rs_i        (rs_data),
        .rt_i        (rt_data),
        .last_o      (core_last),
        .done_o      (md_done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

endmodule

// File: tb/tb_alu_md_control.sv
// Self-checking bench for alu_md_control: directed cases with literal results,
// then random traffic checked every cycle against a behavioural model.
module tb_alu_md_control;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         issue;
    logic [4:0]   ALUOp;
    logic [5:0]   ALUFunction;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [3:0]   ALUOperation;
    logic [1:0]   hilo_sel;
    logic [W-1:0] hilo_data;
    logic         stall;
    logic         busy;
    logic         md_done;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    alu_md_control #(.DATA_WIDTH(W), .ALUOP_WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue        (issue),
        .ALUOp        (ALUOp),
        .ALUFunction  (ALUFunction),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .ALUOperation (ALUOperation),
        .hilo_sel     (hilo_sel),
        .hilo_data    (hilo_data),
        .stall        (stall),
        .busy         (busy),
        .md_done      (md_done),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           busy_left = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic [W-1:0] exp_q[$];

    function automatic logic is_md_i(logic [4:0] op, logic [5:0] f);
        return (op == 5'd7) && (f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
    endfunction

    function automatic logic is_mf_i(logic [4:0] op, logic [5:0] f);
        return (op == 5'd7) && (f inside {6'b010000, 6'b010010});
    endfunction

    function automatic logic [3:0] exp_alu(logic [4:0] op, logic [5:0] f);
        if (op == 5'd7) begin
            case (f)
                6'b100000: return 4'b0011;
                6'b100100: return 4'b0101;
                6'b100111: return 4'b0111;
                6'b100101: return 4'b1000;
                6'b000000: return 4'b0000;
                6'b000010: return 4'b0001;
                default:   return 4'b1001;
            endcase
        end
        case (op)
            5'd1:    return 4'b0011;
            5'd2:    return 4'b0101;
            5'd3:    return 4'b1000;
            5'd4:    return 4'b0010;
            5'd5:    return 4'b0011;
            5'd6:    return 4'b0011;
            5'd8:    return 4'b0100;
            default: return 4'b1001;
        endcase
    endfunction

    // {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] md_result(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            6'b011000: return 64'(sa * sb);
            6'b011001: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (f == 6'b011010) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        logic [63:0] res;
        if (reset) begin
            busy_left = 0;
            m_hi = '0;
            m_lo = '0;
            exp_q.delete();
        end else if (busy_left > 0) begin
            if (busy_left == 1) begin
                m_hi = exp_q.pop_front();
                m_lo = exp_q.pop_front();
            end
            busy_left--;
        end else if (issue && is_md_i(ALUOp, ALUFunction)) begin
            res = md_result(ALUFunction, rs_data, rt_data);
            exp_q.push_back(res[63:32]);
            exp_q.push_back(res[31:0]);
            busy_left = W + 1;
        end
        p_hi = m_hi;
        p_lo = m_lo;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic       eb;
        logic [1:0] es;
        logic [W-1:0] ed;
        if (chk_en) begin
            eb = (busy_left > 0);
            es = (ALUOp == 5'd7 && ALUFunction == 6'b010000) ? 2'b01 :
                 (ALUOp == 5'd7 && ALUFunction == 6'b010010) ? 2'b10 : 2'b00;
            ed = (es == 2'b01) ? p_hi : (es == 2'b10) ? p_lo : '0;
            check("busy", {63'd0, busy}, {63'd0, eb});
            check("md_done", {63'd0, md_done}, {63'd0, (busy_left == 1)});
            check("stall", {63'd0, stall},
                  {63'd0, eb & issue & (is_md_i(ALUOp, ALUFunction) | is_mf_i(ALUOp, ALUFunction))});
            check("alu_operation", {60'd0, ALUOperation}, {60'd0, exp_alu(ALUOp, ALUFunction)});
            check("hilo_sel", {62'd0, hilo_sel}, {62'd0, es});
            check("hilo_data", {32'd0, hilo_data}, {32'd0, ed});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic iss);
        ALUOp = op;
        ALUFunction = f;
        rs_data = a;
        rt_data = b;
        issue = iss;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        drive(5'd7, 6'b010000, '0, '0, 1'b1);
        @(negedge clk);
        hi = hilo_data;
        tick();
        drive(5'd7, 6'b010010, '0, '0, 1'b1);
        @(negedge clk);
        lo = hilo_data;
        tick();
        issue = 1'b0;
    endtask

    task automatic wait_idle(output int pulses);
        pulses = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (md_done) pulses++;
            if (!busy) break;
            tick();
        end
        check("idle_wait_busy", {63'd0, busy}, 64'd0);
        tick();
    endtask

    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input string name);
        logic [31:0] hi, lo;
        int pulses;
        drive(5'd7, f, a, b, 1'b1);
        tick();
        issue = 1'b0;
        wait_idle(pulses);
        check({name, "_done_pulses"}, 64'(pulses), 64'd1);
        read_hilo(hi, lo);
        check({name, "_hi"}, {32'd0, hi}, {32'd0, e_hi});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, e_lo});
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    logic [4:0] sw_op  [14] = '{7, 7, 7, 7, 7, 7, 1, 2, 3, 4, 5, 6, 8, 9};
    logic [5:0] sw_f   [14] = '{6'b100000, 6'b100100, 6'b100111, 6'b100101, 6'b000000, 6'b000010,
                                 0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] sw_exp [14] = '{4'b0011, 4'b0101, 4'b0111, 4'b1000, 4'b0000, 4'b0001,
                                 4'b0011, 4'b0101, 4'b1000, 4'b0010, 4'b0011, 4'b0011,
                                 4'b0100, 4'b1001};

    initial begin
        logic [31:0] hi, lo;
        logic [5:0] md_f [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};
        logic [5:0] lg_f [6] = '{6'b100000, 6'b100100, 6'b100111, 6'b100101, 6'b000000, 6'b000010};
        int pulses, cnt;

        reset = 1'b1;
        drive(5'd0, 6'd0, '0, '0, 1'b0);
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_md_done", {63'd0, md_done}, 64'd0);
        tick();
        read_hilo(hi, lo);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);

        // decode sweep
        for (int i = 0; i < 14; i++) begin
            drive(sw_op[i], sw_f[i], $urandom(), $urandom(), 1'b1);
            @(negedge clk);
            check("decode", {60'd0, ALUOperation}, {60'd0, sw_exp[i]});
            check("decode_no_busy", {63'd0, busy}, 64'd0);
            tick();
        end
        issue = 1'b0;

        // directed multiply / divide with hand-computed results
        run_md(6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3");
        run_md(6'b011001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, "multu_x3");
        run_md(6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
        run_md(6'b011011, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_by0");
        run_md(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");

        // MFLO right behind a DIV stalls until the result lands
        drive(5'd7, 6'b011010, 32'hFFFFFFF9, 32'd2, 1'b1);
        tick();
        drive(5'd7, 6'b010010, '0, '0, 1'b1);
        cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!stall) break;
            cnt++;
            tick();
        end
        check("mflo_stall_cycles", 64'(cnt), 64'd33);
        check("mflo_sel", {62'd0, hilo_sel}, 64'd2);
        check("mflo_data", {32'd0, hilo_data}, 64'hFFFFFFFD);
        tick();
        issue = 1'b0;

        // ADD while the sequencer is busy proceeds without stall
        drive(5'd7, 6'b011000, 32'd5, 32'd6, 1'b1);
        tick();
        drive(5'd7, 6'b100000, 32'd1, 32'd2, 1'b1);
        @(negedge clk);
        check("add_busy_stall", {63'd0, stall}, 64'd0);
        check("add_busy_busy", {63'd0, busy}, 64'd1);
        tick();
        issue = 1'b0;
        wait_idle(pulses);

        // back-to-back MULT: the second is held until the first completes
        drive(5'd7, 6'b011000, 32'd1000, 32'd1000, 1'b1);
        tick();
        drive(5'd7, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        pulses = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (md_done) pulses++;
            if (!stall) break;
            tick();
        end
        check("b2b_first_done", 64'(pulses), 64'd1);
        tick();
        issue = 1'b0;
        wait_idle(pulses);
        check("b2b_second_done", 64'(pulses), 64'd1);
        read_hilo(hi, lo);
        check("b2b_hi", {32'd0, hi}, 64'd0);
        check("b2b_lo", {32'd0, lo}, 64'd1);

        // reset in the middle of RUN aborts the operation
        drive(5'd7, 6'b011001, 32'd9, 32'd9, 1'b1);
        tick();
        issue = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_md_done", {63'd0, md_done}, 64'd0);
        tick();
        read_hilo(hi, lo);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        run_md(6'b011000, 32'd12345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7, "mult_after_abort");

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 2000; c++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: drive(5'd7, md_f[$urandom_range(0, 3)], rnd_opnd(), rnd_opnd(), 1'b1);
                4, 5:       drive(5'd7, ($urandom_range(0, 1) != 0) ? 6'b010000 : 6'b010010,
                                  $urandom(), $urandom(), 1'b1);
                6, 7:       drive(5'd7, lg_f[$urandom_range(0, 5)], $urandom(), $urandom(), 1'b1);
                8:          drive(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                                  $urandom(), $urandom(), 1'b1);
                default:    drive(5'd7, 6'($urandom_range(0, 63)), rnd_opnd(), rnd_opnd(), 1'b1);
            endcase
            if ($urandom_range(0, 3) == 0) issue = 1'b0;
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        issue = 1'b0;
        wait_idle(pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
